instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage between the 256x32 instruction ROM and decode. Holds the PC, issues one
//  ROM read per cycle into a registered (1-cycle latency) ROM port, and buffers fetched
//  words with their PCs in a small FIFO. Decode drains the FIFO with a valid/ready handshake.
//  Accepts PC redirects from downstream and reports end of program on fetch_complete.
// PARAMETERS
//  ROM_DEPTH   256  instruction words in ROM; the PC range is 0 .. 4*ROM_DEPTH-4
//  ROM_AW      8    ROM word-address width (clog2 of ROM_DEPTH)
//  FIFO_DEPTH  4    fetch-queue entries (power of 2, >=2)
//  RESET_PC    0    byte PC loaded at reset (word aligned)
// PORTS
//  clk             in   1       clock
//  reset           in   1       synchronous, active-low reset (acts on the clk edge while low)
//  rom_en          out  1       ROM read strobe
//  rom_addr        out  ROM_AW  ROM word address = pc[ROM_AW+1:2]
//  rom_data        in   32      ROM word; valid the cycle after rom_en
//  redirect_valid  in   1       flush the queue and restart fetch at redirect_pc
//  redirect_pc     in   32      new byte PC; bits [1:0] ignored (forced 0)
//  out_valid       out  1       FIFO head valid
//  out_ready       in   1       decode accepts the head
//  out_instr       out  32      head instruction
//  out_pc          out  32      byte PC of head instruction
//  fetch_complete  out  1       program end reached; queue empty; no read in flight
// BEHAVIOUR
//  Reset (reset=0): pc=RESET_PC, FIFO empty, in-flight flag clear, state=RUN.
//   All outputs 0 (rom_en, rom_addr, out_valid, out_instr, out_pc, fetch_complete).
//  States: RUN (issuing), DRAIN (stop seen, queue emptying), DONE.
//  Issue (RUN only): rom_en=1 when count + inflight < FIFO_DEPTH; pc += 4 on issue.
//   A pop in the same cycle does not free a slot until the next cycle.
//  Response: the cycle after rom_en, {rom_data, issued pc} pushes to the tail,
//   unless killed by a redirect. Sustained rate is 1 instr/cycle with out_ready=1.
//  Handshake: a transfer occurs when out_valid & out_ready. out_instr/out_pc stay stable
//   while out_valid & !out_ready. out_valid never drops without a transfer or a redirect.
//  End of ROM: when pc[31:2] >= ROM_DEPTH in RUN, stop issuing and go to DRAIN.
//   No wrap-around to address 0.
//  DRAIN -> DONE when the FIFO is empty and nothing is in flight.
//   fetch_complete = (state==DONE); it is registered and stays high until redirect or reset.
//  Redirect (highest priority): next cycle the FIFO is empty, any in-flight response is
//   dropped, pc = {redirect_pc[31:2],2'b00}, state=RUN, and fetch_complete=0.
//   A head transfer in the same cycle counts as consumed; decode discards it.
//   A redirect beyond ROM end enters DRAIN, then DONE.
//  Simultaneous push and pop: both occur, and count is unchanged.
//   A push into an empty FIFO is visible on out_* the next cycle (no bypass).
//  Reset asserted mid-operation overrides redirect and flow control.
//   Pending ROM data is discarded.
// CONFIGURATION
//  FETCH_HALT_EN defined: a response word == 32'h0000_0000 is treated as end of program.
//   It is not enqueued, any younger in-flight read is dropped, and issue stops.
//   RUN -> DRAIN. Earlier queued words still drain normally.
//  FETCH_HALT_EN undefined: zero words are enqueued as ordinary instructions.
//   Only ROM end or reset/redirect ends fetch.
// TESTING
//  1 Reset, out_ready=1, ROM[i]=i+1: out_instr=1,2,3... on consecutive cycles.
//    First out_valid 2 cycles after reset release; out_pc=0,4,8...
//  2 out_ready=0 for 10 cycles: exactly FIFO_DEPTH=4 entries fill and rom_en drops to 0.
//    Head holds instr 1/pc 0. Release: 4 queued then 5,6... with no gap or duplicate.
//  3 redirect_valid with redirect_pc=32'h43 while 3 queued + 1 in flight: next cycle
//    out_valid=0. Then out_pc=0x40 with ROM[16] first; the killed word never appears.
//  4 No halt word, ROM_DEPTH=256, out_ready=1: last out_pc=0x3FC.
//    fetch_complete rises after it drains and rom_addr never wraps to 0.
//  5 FETCH_HALT_EN, ROM[5]=0: instrs 0..4 delivered, nothing with pc>=0x14.
//    fetch_complete=1 once drained. Redirect to 0 clears it and fetch restarts.
//  6 reset low mid-stream with a full FIFO: next cycle all outputs 0.
//    After release the stream restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage between a 256x32 instruction ROM (registered read port, one
//   cycle latency) and decode. Holds the byte PC, issues at most one ROM read
//   per cycle, and buffers each returned word together with its PC in a small
//   FIFO that decode drains with a valid/ready handshake. Downstream redirects
//   flush the queue and restart fetch; fetch_complete flags end of program.
//
//   Optional feature macro: FETCH_HALT_EN
//     defined   : a returned word of 32'h0 ends the program (not enqueued,
//                 younger read dropped, issue stops).
//     undefined : zero words are ordinary instructions.
//
// Ports
//   clk             clock
//   reset           synchronous, active-low reset
//   rom_en          ROM read strobe
//   rom_addr        ROM word address (pc[ROM_AW+1:2])
//   rom_data        ROM word, valid the cycle after rom_en
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new byte PC, bits [1:0] ignored
//   out_valid       queue head valid
//   out_ready       decode accepts the head
//   out_instr       head instruction
//   out_pc          byte PC of the head instruction
//   fetch_complete  program end reached, queue empty, no read in flight
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int          ROM_DEPTH  = 256,
   parameter int          ROM_AW     = 8,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   output logic              rom_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
   output logic              fetch_complete
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]        state;
   logic [31:0]       pc;
   logic [31:0]       rd_pc;      // PC of the read currently in flight
   logic              inflight;
   logic [ROM_AW-1:0] addr_q;     // last issued word address
   logic [CW-1:0]     count;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [31:0]       instr_mem [FIFO_DEPTH];
   logic [31:0]       pc_mem    [FIFO_DEPTH];

   logic              pc_in_rom;
   logic              issue;
   logic              resp_halt;
   logic              push;
   logic              pop;

   assign pc_in_rom = (pc[31:2] < 30'(ROM_DEPTH));

   // Slots are reserved at issue time: queued entries plus the read in flight
   // must leave room, and a pop this cycle only frees a slot next cycle.
   // NOTE: rom_en is qualified with reset so no read is strobed while reset is
   // held low, even though the registered state already reads as RUN.
   assign issue = reset && (state == ST_RUN) && pc_in_rom &&
                  ((count + CW'(inflight)) < CW'(FIFO_DEPTH));

`ifdef FETCH_HALT_EN
   assign resp_halt = inflight && (rom_data == 32'h0000_0000);
`else
   assign resp_halt = 1'b0;
`endif

   assign push = inflight && !resp_halt;
   assign pop  = out_valid && out_ready;

   // Once fetch stops, the address bus holds the last issued word address so
   // it never falls back to 0 after the top of the ROM.
   assign rom_en         = issue;
   assign rom_addr       = issue ? pc[ROM_AW+1:2] : addr_q;
   assign out_valid      = (count != '0);
   assign out_instr      = out_valid ? instr_mem[rd_ptr] : 32'h0;
   assign out_pc         = out_valid ? pc_mem[rd_ptr]    : 32'h0;
   assign fetch_complete = (state == ST_DONE);

   // NOTE: all state registers use non-blocking assignments so every update
   // below sees the pre-edge values of count, inflight and state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_RUN;
         pc       <= RESET_PC;
         rd_pc    <= 32'h0;
         inflight <= 1'b0;
         addr_q   <= '0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else if (redirect_valid) begin
         // A head transfer this cycle is consumed and discarded by decode;
         // the read in flight is dropped by clearing inflight.
         state    <= ST_RUN;
         pc       <= redirect_pc & ~32'h3;
         inflight <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         if (issue) begin
            pc     <= pc + 32'd4;
            rd_pc  <= pc;
            addr_q <= pc[ROM_AW+1:2];
         end
         // A halt word also kills the read issued alongside it.
         inflight <= issue && !resp_halt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         case (state)
            ST_RUN:   if (!pc_in_rom || resp_halt) state <= ST_DRAIN;
            ST_DRAIN: if ((count == '0) && !inflight) state <= ST_DONE;
            default:  state <= state;
         endcase
      end
   end

   // NOTE: queue storage has no reset; count gates out_valid and the data
   // outputs, so stale entries are never visible.
   always_ff @(posedge clk) begin
      if (reset && !redirect_valid && push) begin
         instr_mem[wr_ptr] <= rom_data;
         pc_mem[wr_ptr]    <= rd_pc;
      end
   end

endmodule
